mem_port_arbiter: RTL and testbench

- Shares the single external memory port between the instruction-fetch requester and the load/store requester of the core.
- Sequences each access as request -> memory command -> memory response -> requester acknowledge.
- Arbitrates with data-first priority and a bounded starvation guard for fetch.
- Adds a response timeout so a missing mem_valid cannot hang the core.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_err;

  logic                  d_req;
  logic                  d_we;
  logic [1:0]            d_wstrb;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_ready;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_err;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read_enable;
  logic                  mem_write_enable;
  logic [1:0]            mem_write_wstrb;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_valid;
  logic [DATA_WIDTH-1:0] mem_read_data;

  // Environment side: core requesters plus the external memory.
  modport master (
    output if_req, if_addr, d_req, d_we, d_wstrb, d_addr, d_wdata,
    output mem_valid, mem_read_data,
    input  if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
    input  mem_address, mem_read_enable, mem_write_enable, mem_write_wstrb, mem_write_data
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_wstrb, d_addr, d_wdata,
    input  mem_valid, mem_read_data,
    output if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
    output mem_address, mem_read_enable, mem_write_enable, mem_write_wstrb, mem_write_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and load/store.
// Data wins contention until MAX_DATA_STREAK consecutive grants have starved
// fetch; a response timeout keeps a silent memory from hanging the core.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT         = 255
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned SW     = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
  localparam int unsigned TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TMO_EN = (TIMEOUT != 0);
  localparam logic [1:0]  WSTRB_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_D = 2'd2, RESP = 2'd3} state_t;

  state_t                state_q, state_d;
  logic                  data_owner_q, data_owner_d;
  logic [SW-1:0]         streak_q, streak_d;
  logic [TW-1:0]         tmo_q, tmo_d, tmo_inc;
  logic                  tmo_hit, take_data;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            wstrb_q, wstrb_d;
  logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic                  if_ready_q, if_ready_d, if_err_q, if_err_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  d_ready_q, d_ready_d, d_err_q, d_err_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  // Next-state, grant and completion decisions.
  always_comb begin
    state_d      = state_q;
    data_owner_d = data_owner_q;
    streak_d     = streak_q;
    tmo_d        = tmo_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rd_en_d      = rd_en_q;
    wr_en_d      = wr_en_q;
    if_ready_d   = 1'b0;
    if_err_d     = 1'b0;
    if_rdata_d   = '0;
    d_ready_d    = 1'b0;
    d_err_d      = 1'b0;
    d_rdata_d    = '0;
    tmo_inc      = tmo_q + TW'(1);
    tmo_hit      = TMO_EN && (tmo_inc == TW'(TIMEOUT));
    take_data    = bus.d_req && (!bus.if_req || (streak_q < SW'(MAX_DATA_STREAK)));

    case (state_q)
      IDLE: begin
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        tmo_d   = '0;
        if (take_data) begin
          state_d      = BUSY_D;
          data_owner_d = 1'b1;
          addr_d       = bus.d_addr;
          wdata_d      = bus.d_wdata;
          wstrb_d      = bus.d_wstrb;
          rd_en_d      = !bus.d_we;
          wr_en_d      = bus.d_we;
          // Streak only grows while fetch is actually waiting; it stops at the limit.
          streak_d     = bus.if_req ? streak_q + SW'(1) : '0;
        end else if (bus.if_req) begin
          state_d      = BUSY_IF;
          data_owner_d = 1'b0;
          addr_d       = bus.if_addr;
          wdata_d      = '0;
          wstrb_d      = WSTRB_WORD;
          rd_en_d      = 1'b1;
          wr_en_d      = 1'b0;
          streak_d     = '0;
        end
      end
      BUSY_IF, BUSY_D: begin
        tmo_d = tmo_inc;
        // A response arriving on the timeout cycle still counts as success.
        if (bus.mem_valid || tmo_hit) begin
          state_d = RESP;
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          tmo_d   = '0;
          if (data_owner_q) begin
            d_ready_d = 1'b1;
            d_err_d   = !bus.mem_valid;
            d_rdata_d = (bus.mem_valid && !wr_en_q) ? bus.mem_read_data : '0;
          end else begin
            if_ready_d = 1'b1;
            if_err_d   = !bus.mem_valid;
            if_rdata_d = bus.mem_valid ? bus.mem_read_data : '0;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        tmo_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any in-flight access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      data_owner_q <= 1'b0;
      streak_q     <= '0;
      tmo_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      if_ready_q   <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_ready_q    <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      data_owner_q <= data_owner_d;
      streak_q     <= streak_d;
      tmo_q        <= tmo_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      if_ready_q   <= if_ready_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      d_ready_q    <= d_ready_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign bus.if_ready         = if_ready_q;
  assign bus.if_err           = if_err_q;
  assign bus.if_rdata         = if_rdata_q;
  assign bus.d_ready          = d_ready_q;
  assign bus.d_err            = d_err_q;
  assign bus.d_rdata          = d_rdata_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_read_enable  = rd_en_q;
  assign bus.mem_write_enable = wr_en_q;
  assign bus.mem_write_wstrb  = wstrb_q;
  assign bus.mem_write_data   = wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus
// a randomized run compared cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXS = 4;
  localparam int unsigned TMO  = 5;
  localparam int MEM_RANDOM = 0, MEM_FIXED = 1, MEM_NEVER = 2, MEM_SPUR = 3;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_DATA_STREAK(MAXS), .TIMEOUT(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bif)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // An access is granted on one edge, stays outstanding until the memory answers
  // or TMO edges have elapsed since the grant, and is acknowledged for one cycle.
  int            cyc = 0;
  int            m_phase = 0;   // 0 waiting for grant, 1 outstanding, 2 acknowledging
  bit            m_owner_d = 1'b0, m_has_owner = 1'b0, m_we = 1'b0;
  int            m_streak = 0, m_grant_cyc = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [1:0]    m_wstrb = '0;
  logic          e_if_ready = 1'b0, e_if_err = 1'b0, e_d_ready = 1'b0, e_d_err = 1'b0;
  logic [DW-1:0] e_if_rdata = '0, e_d_rdata = '0;
  string         grant_log = "";

  task automatic model_clear_resp();
    e_if_ready = 1'b0; e_if_err = 1'b0; e_if_rdata = '0;
    e_d_ready  = 1'b0; e_d_err  = 1'b0; e_d_rdata  = '0;
  endtask

  task automatic model_finish(input logic [DW-1:0] data, input logic err);
    if (m_owner_d) begin e_d_ready = 1'b1; e_d_rdata = data; e_d_err = err; end
    else begin e_if_ready = 1'b1; e_if_rdata = data; e_if_err = err; end
    m_phase = 2;
  endtask

  initial forever begin
    @(posedge clock or negedge reset);
    if (reset !== 1'b1) begin
      m_phase = 0; m_streak = 0; m_has_owner = 1'b0;
      model_clear_resp();
    end else begin
      cyc++;
      if (m_phase == 2) begin
        model_clear_resp();
        m_phase = 0;
      end else if (m_phase == 1) begin
        if (bif.mem_valid) model_finish(m_we ? '0 : bif.mem_read_data, 1'b0);
        else if (TMO != 0 && cyc - m_grant_cyc == int'(TMO)) model_finish('0, 1'b1);
      end else if (bif.d_req && (!bif.if_req || m_streak < int'(MAXS))) begin
        m_streak = bif.if_req ? ((m_streak + 1 > int'(MAXS)) ? int'(MAXS) : m_streak + 1) : 0;
        m_phase = 1; m_grant_cyc = cyc; m_owner_d = 1'b1; m_has_owner = 1'b1;
        m_we = bif.d_we; m_addr = bif.d_addr; m_wdata = bif.d_wdata; m_wstrb = bif.d_wstrb;
        grant_log = {grant_log, "D"};
      end else if (bif.if_req) begin
        m_streak = 0;
        m_phase = 1; m_grant_cyc = cyc; m_owner_d = 1'b0; m_has_owner = 1'b1;
        m_we = 1'b0; m_addr = bif.if_addr; m_wdata = '0; m_wstrb = 2'b10;
        grant_log = {grant_log, "I"};
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial forever begin
    @(negedge clock);
    if (reset === 1'b1) begin
      chk("mem_read_enable",  DW'(bif.mem_read_enable),  DW'(m_phase == 1 && !m_we));
      chk("mem_write_enable", DW'(bif.mem_write_enable), DW'(m_phase == 1 && m_we));
      if (m_phase == 1) begin
        chk("mem_address",     DW'(bif.mem_address),     DW'(m_addr));
        chk("mem_write_wstrb", DW'(bif.mem_write_wstrb), DW'(m_wstrb));
        if (m_we) chk("mem_write_data", bif.mem_write_data, m_wdata);
      end
      chk("if_ready", DW'(bif.if_ready), DW'(e_if_ready));
      chk("d_ready",  DW'(bif.d_ready),  DW'(e_d_ready));
      if (e_if_ready || (m_has_owner && m_owner_d)) begin
        chk("if_rdata", bif.if_rdata, e_if_rdata);
        chk("if_err",   DW'(bif.if_err), DW'(e_if_err));
      end
      if (e_d_ready || (m_has_owner && !m_owner_d)) begin
        chk("d_rdata", bif.d_rdata, e_d_rdata);
        chk("d_err",   DW'(bif.d_err), DW'(e_d_err));
      end
    end
  end

  // ---------------- memory responder ----------------
  int            mem_mode = MEM_NEVER;
  int            mem_lat = 1;
  logic [DW-1:0] mem_word = '0;
  int            en_cnt = 0;
  int            cur_lat = 1;

  initial begin
    bif.mem_valid = 1'b0;
    bif.mem_read_data = '0;
    forever begin
      @(negedge clock);
      #1;
      bif.mem_valid = 1'b0;
      if (reset !== 1'b1) begin
        en_cnt = 0;
      end else if (bif.mem_read_enable || bif.mem_write_enable) begin
        en_cnt++;
        if (en_cnt == 1) cur_lat = (mem_mode == MEM_FIXED) ? mem_lat : int'($urandom_range(1, 7));
        if ((mem_mode == MEM_FIXED || mem_mode == MEM_RANDOM) && en_cnt == cur_lat) begin
          bif.mem_valid = 1'b1;
          bif.mem_read_data = (mem_mode == MEM_FIXED) ? mem_word : $urandom;
        end
      end else begin
        en_cnt = 0;
        if (mem_mode == MEM_SPUR || (mem_mode == MEM_RANDOM && $urandom_range(0, 5) == 0)) begin
          bif.mem_valid = 1'b1;
          bif.mem_read_data = $urandom;
        end
      end
    end
  end

  // ---------------- requesters ----------------
  int            r_rd_cyc, r_wr_cyc, r_rdy, r_other;
  logic [DW-1:0] r_rdata, r_wdata;
  logic [AW-1:0] r_addr;
  logic [1:0]    r_wstrb;
  logic          r_err;

  // Issue one request, hold it until acknowledged, then observe for 30 cycles total.
  task automatic access(input bit is_d, input bit we, input logic [1:0] wstrb,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    logic own, oth;
    r_rd_cyc = 0; r_wr_cyc = 0; r_rdy = 0; r_other = 0;
    r_rdata = '0; r_wdata = '0; r_addr = '0; r_wstrb = '0; r_err = 1'b0;
    if (is_d) begin
      bif.d_req = 1'b1; bif.d_we = we; bif.d_wstrb = wstrb; bif.d_addr = addr; bif.d_wdata = wdata;
    end else begin
      bif.if_req = 1'b1; bif.if_addr = addr;
    end
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (bif.mem_read_enable) r_rd_cyc++;
      if (bif.mem_write_enable) begin r_wr_cyc++; r_wdata = bif.mem_write_data; end
      if (bif.mem_read_enable || bif.mem_write_enable) begin
        r_addr = bif.mem_address; r_wstrb = bif.mem_write_wstrb;
      end
      own = is_d ? bif.d_ready : bif.if_ready;
      oth = is_d ? bif.if_ready : bif.d_ready;
      if (oth) r_other++;
      if (own) begin
        r_rdy++;
        r_rdata = is_d ? bif.d_rdata : bif.if_rdata;
        r_err   = is_d ? bif.d_err : bif.if_err;
      end
      #1;
      if (own) begin
        if (is_d) bif.d_req = 1'b0; else bif.if_req = 1'b0;
      end
    end
  endtask

  task automatic new_fetch();
    bif.if_req = 1'b1; bif.if_addr = $urandom;
  endtask

  task automatic new_data();
    bif.d_req = 1'b1; bif.d_we = 1'($urandom_range(0, 1));
    bif.d_wstrb = 2'($urandom_range(0, 2)); bif.d_addr = $urandom; bif.d_wdata = $urandom;
  endtask

  // Random requesters: drop after acknowledge, optionally present a new request.
  task automatic rand_step(input bit allow_new);
    if (bif.if_req) begin
      if (bif.if_ready) begin
        bif.if_req = 1'b0;
        if (allow_new && $urandom_range(0, 1) == 1) new_fetch();
      end
    end else if (allow_new && $urandom_range(0, 2) == 0) new_fetch();
    if (bif.d_req) begin
      if (bif.d_ready) begin
        bif.d_req = 1'b0;
        if (allow_new && $urandom_range(0, 1) == 1) new_data();
      end
    end else if (allow_new && $urandom_range(0, 2) == 0) new_data();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int    cnt, en_seen, start;
    bit    busy_before, drained;
    string order;
    reset = 1'b0;
    bif.if_req = 1'b0; bif.if_addr = '0;
    bif.d_req = 1'b0; bif.d_we = 1'b0; bif.d_wstrb = '0; bif.d_addr = '0; bif.d_wdata = '0;
    repeat (3) @(negedge clock);
    chk("reset_ctrl", DW'({bif.mem_read_enable, bif.mem_write_enable, bif.if_ready, bif.if_err,
                           bif.d_ready, bif.d_err, bif.mem_write_wstrb}), '0);
    chk("reset_addr",  DW'(bif.mem_address), '0);
    chk("reset_wdata", bif.mem_write_data, '0);
    chk("reset_rdata", bif.if_rdata | bif.d_rdata, '0);
    #1 reset = 1'b1;

    // Single load, memory answers two cycles after the enable.
    mem_mode = MEM_FIXED; mem_lat = 2; mem_word = 32'hDEADBEEF;
    access(1'b1, 1'b0, 2'b10, 32'h100, '0);
    chk("load_rd_cycles", DW'(r_rd_cyc), 32'd2);
    chk("load_addr",      DW'(r_addr), 32'h100);
    chk("load_wstrb",     DW'(r_wstrb), 32'd2);
    chk("load_ready_cnt", DW'(r_rdy), 32'd1);
    chk("load_rdata",     r_rdata, 32'hDEADBEEF);
    chk("load_err",       DW'(r_err), 32'd0);
    chk("load_if_ready",  DW'(r_other), 32'd0);

    // Store of a halfword; returned memory data must not leak into d_rdata.
    mem_lat = 1; mem_word = 32'hFFFFFFFF;
    access(1'b1, 1'b1, 2'b01, 32'h204, 32'h12345678);
    chk("store_wr_cycles", DW'(r_wr_cyc), 32'd1);
    chk("store_rd_cycles", DW'(r_rd_cyc), 32'd0);
    chk("store_wdata",     r_wdata, 32'h12345678);
    chk("store_wstrb",     DW'(r_wstrb), 32'd1);
    chk("store_ready_cnt", DW'(r_rdy), 32'd1);
    chk("store_rdata",     r_rdata, 32'd0);

    // Timeout on a fetch, then a normal fetch.
    mem_mode = MEM_NEVER;
    access(1'b0, 1'b0, 2'b00, 32'h40, '0);
    chk("tmo_en_cycles", DW'(r_rd_cyc), DW'(TMO));
    chk("tmo_wstrb",     DW'(r_wstrb), 32'd2);
    chk("tmo_ready_cnt", DW'(r_rdy), 32'd1);
    chk("tmo_err",       DW'(r_err), 32'd1);
    chk("tmo_rdata",     r_rdata, 32'd0);
    mem_mode = MEM_FIXED; mem_lat = 1; mem_word = 32'hCAFEF00D;
    access(1'b0, 1'b0, 2'b00, 32'h44, '0);
    chk("after_tmo_err",   DW'(r_err), 32'd0);
    chk("after_tmo_rdata", r_rdata, 32'hCAFEF00D);

    // Response on the very cycle the timeout would fire.
    mem_lat = int'(TMO); mem_word = 32'h0BADF00D;
    access(1'b0, 1'b0, 2'b00, 32'h48, '0);
    chk("edge_en_cycles", DW'(r_rd_cyc), DW'(TMO));
    chk("edge_err",       DW'(r_err), 32'd0);
    chk("edge_rdata",     r_rdata, 32'h0BADF00D);

    // Spurious mem_valid with nothing outstanding.
    mem_mode = MEM_SPUR; cnt = 0; en_seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (bif.if_ready || bif.d_ready) cnt++;
      if (bif.mem_read_enable || bif.mem_write_enable) en_seen++;
      #1;
    end
    chk("spur_ready", DW'(cnt), 32'd0);
    chk("spur_enables", DW'(en_seen), 32'd0);

    // Contention: both requesters held high, one-cycle memory.
    mem_mode = MEM_FIXED; mem_lat = 1; mem_word = 32'h5A5A5A5A;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    start = grant_log.len();
    order = "";
    bif.d_we = 1'b0; bif.d_wstrb = 2'b10; bif.d_addr = 32'h800; bif.if_addr = 32'h900;
    bif.if_req = 1'b1; bif.d_req = 1'b1;
    for (int i = 0; i < 60 && order.len() < 10; i++) begin
      @(negedge clock);
      if (bif.d_ready) order = {order, "D"};
      if (bif.if_ready) order = {order, "I"};
      #1;
      if (order.len() >= 10) begin bif.if_req = 1'b0; bif.d_req = 1'b0; end
    end
    bif.if_req = 1'b0; bif.d_req = 1'b0;
    chk_str("dut_grant_order", order, "DDDDIDDDDI");
    chk_str("model_grant_order", grant_log.substr(start, start + 9), "DDDDIDDDDI");
    repeat (4) @(negedge clock);
    #1;

    // Reset while a load is outstanding.
    mem_mode = MEM_NEVER;
    bif.d_req = 1'b1; bif.d_we = 1'b0; bif.d_addr = 32'h300; bif.d_wstrb = 2'b10;
    @(negedge clock);
    @(negedge clock);
    busy_before = bif.mem_read_enable;
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_was_busy", DW'(busy_before), 32'd1);
    chk("rst_mid_ctrl", DW'({bif.mem_read_enable, bif.mem_write_enable, bif.if_ready, bif.if_err,
                             bif.d_ready, bif.d_err, bif.mem_write_wstrb}), '0);
    chk("rst_mid_addr", DW'(bif.mem_address), '0);
    bif.d_req = 1'b0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clock);
      if (bif.d_ready) cnt++;
      #1;
    end
    chk("rst_mid_no_ready", DW'(cnt), 32'd0);
    mem_mode = MEM_FIXED; mem_lat = 2; mem_word = 32'h11111111;
    access(1'b0, 1'b0, 2'b00, 32'h0, '0);
    chk("rst_fetch_ready", DW'(r_rdy), 32'd1);
    chk("rst_fetch_rdata", r_rdata, 32'h11111111);
    chk("rst_fetch_err",   DW'(r_err), 32'd0);
    chk("rst_fetch_addr",  DW'(r_addr), 32'h0);
    chk("rst_no_d_ready",  DW'(r_other), 32'd0);

    // Randomized traffic against the model, then drain.
    mem_mode = MEM_RANDOM;
    repeat (4000) begin
      @(negedge clock);
      #1;
      rand_step(1'b1);
    end
    drained = 1'b0;
    for (int i = 0; i < 200 && !drained; i++) begin
      @(negedge clock);
      #1;
      rand_step(1'b0);
      drained = !bif.if_req && !bif.d_req;
    end
    chk("drain_complete", DW'(drained), 32'd1);
    repeat (4) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
